pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/pc_adder4.sv | 12 +
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pc_fetch_unit_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StValid = 2'd2,
    StTrap  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_e;

  // Only the two low address bits decide word alignment.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Core/memory-facing signal bundle of the fetch unit.
// master: the fetch unit itself; slave: the core + instruction memory side.
interface pc_fetch_unit_if;
  logic [31:0] MUX3Res;
  logic        NextPCSrc;
  logic        InstrDone;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Fault;
  logic [1:0]  FaultCause;

  modport master (
    input  MUX3Res, NextPCSrc, InstrDone, IMemAck, IMemRData,
    output PC, PCPlus4, IMemReq, IMemAddr, Instr, InstrValid, Fault, FaultCause
  );

  modport slave (
    output MUX3Res, NextPCSrc, InstrDone, IMemAck, IMemRData,
    input  PC, PCPlus4, IMemReq, IMemAddr, Instr, InstrValid, Fault, FaultCause
  );
endinterface

// File: rtl/pc_adder4.sv
// Combinational PC + 4 adder feeding the sequential input of the next-PC mux.
module pc_adder4
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc + INSTR_BYTES;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction from
// instruction memory, hands it to the core and traps on misaligned targets or
// a memory that never acknowledges.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.master bus
);

  localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT + 1);
  // Value of the counter during the last WAIT cycle that may still see an ack.
  localparam logic [CntW-1:0] TmoLast = CntW'(ACK_TIMEOUT - 1);

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              req_q;
  logic              valid_q;
  logic              fault_q;
  fault_e            cause_q;
  logic [CntW-1:0]   tmo_cnt_q;
  // Counts taken redirects; not a port, observed hierarchically.
  logic [31:0]       redirect_cnt_q;
  logic [31:0]       pc_plus4;

  pc_adder4 u_adder4 (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  // FSM with registered outputs; InstrDone only matters in VALID, IMemAck only in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StFetch;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      req_q          <= 1'b1;
      valid_q        <= 1'b0;
      fault_q        <= 1'b0;
      cause_q        <= FAULT_NONE;
      tmo_cnt_q      <= '0;
      redirect_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          state_q   <= StWait;
          tmo_cnt_q <= '0;
        end
        StWait: begin
          // Ack wins over a timeout expiring on the same edge.
          if (bus.IMemAck) begin
            instr_q <= bus.IMemRData;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StValid;
          end else if (tmo_cnt_q == TmoLast) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            cause_q <= FAULT_TIMEOUT;
            state_q <= StTrap;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StValid: begin
          if (bus.InstrDone) begin
            valid_q <= 1'b0;
            if (bus.NextPCSrc) begin
              redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (is_word_aligned(bus.MUX3Res[1:0])) begin
              pc_q    <= bus.MUX3Res;
              req_q   <= 1'b1;
              state_q <= StFetch;
            end else begin
              fault_q <= 1'b1;
              cause_q <= FAULT_MISALIGN;
              state_q <= StTrap;
            end
          end
        end
        StTrap: begin
          state_q <= StTrap;
        end
        default: begin
          state_q <= StTrap;
        end
      endcase
    end
  end

  // Request is forced low while reset is held, before the first reset edge lands.
  always_comb begin
    bus.PC         = pc_q;
    bus.PCPlus4    = pc_plus4;
    bus.IMemAddr   = pc_q;
    bus.IMemReq    = req_q & rst_n;
    bus.Instr      = instr_q;
    bus.InstrValid = valid_q;
    bus.Fault      = fault_q;
    bus.FaultCause = cause_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the stimulus process predicts events
// (request, instruction valid, fault, reset) and queues them; a monitor pops
// and checks them as the DUT presents them.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned ACK_TIMEOUT = 16;

  typedef enum {EvReq, EvValid, EvFault, EvReset} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  cause;
    logic [31:0] redir;
  } ev_t;

  logic clk;
  logic rst_n;
  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC    (RESET_PC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rst_smp;
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  bit          m_trapped = 0;
  logic [31:0] m_trap_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst_n;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(ev_kind_e k, int c, logic [31:0] pc, logic [31:0] instr,
                                  logic [1:0] cause, logic [31:0] redir);
    ev_t e;
    e.kind = k; e.cyc = c; e.pc = pc; e.instr = instr; e.cause = cause; e.redir = redir;
    exp_q.push_back(e);
  endfunction

  task automatic get_ev(input ev_kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_%s: got unexpected %s expected none (cycle %0d)", k.name(), k.name(),
               cyc);
    end else if (exp_q[0].kind != k) begin
      n_fail++;
      $display("FAIL event_%s: got %s expected %s (cycle %0d)", k.name(), k.name(),
               exp_q[0].kind.name(), cyc);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: samples on the falling edge, stimulus drives 1 time unit after it.
  logic        prev_req = 0, prev_valid = 0, prev_fault = 0;
  bit          rst_checked = 0;
  logic [31:0] last_instr, last_pc;
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!rst_n) begin
      if (rst_smp === 1'b0 && !rst_checked) begin
        get_ev(EvReset, e, ok);
        if (ok) begin
          chk("rst_pc", bus.PC, RESET_PC);
          chk("rst_instr", bus.Instr, 32'h0);
          chk("rst_valid", 32'(bus.InstrValid), 32'h0);
          chk("rst_fault", 32'(bus.Fault), 32'h0);
          chk("rst_cause", 32'(bus.FaultCause), 32'(FAULT_NONE));
          chk("rst_req", 32'(bus.IMemReq), 32'h0);
          chk("rst_state", 32'(dut.state_q), 32'(StFetch));
          chk("rst_redir", dut.redirect_cnt_q, 32'h0);
        end
        rst_checked = 1;
      end
      prev_req = 0; prev_valid = 0; prev_fault = 0;
    end else begin
      rst_checked = 0;
      chk("addr_eq_pc", bus.IMemAddr, bus.PC);
      if (bus.IMemReq && !prev_req) begin
        get_ev(EvReq, e, ok);
        if (ok) begin
          chk("req_cycle", cyc, e.cyc);
          chk("req_addr", bus.IMemAddr, e.pc);
        end
      end
      if (bus.InstrValid && !prev_valid) begin
        get_ev(EvValid, e, ok);
        if (ok) begin
          chk("valid_cycle", cyc, e.cyc);
          chk("valid_instr", bus.Instr, e.instr);
          chk("valid_pc", bus.PC, e.pc);
          chk("valid_pcplus4", bus.PCPlus4, e.pc + 32'd4);
          chk("valid_req_low", 32'(bus.IMemReq), 32'h0);
          chk("valid_redir", dut.redirect_cnt_q, e.redir);
          last_instr = e.instr;
          last_pc    = e.pc;
        end
      end else if (bus.InstrValid) begin
        chk("hold_instr", bus.Instr, last_instr);
        chk("hold_pc", bus.PC, last_pc);
      end
      if (bus.Fault && !prev_fault) begin
        get_ev(EvFault, e, ok);
        if (ok) begin
          chk("fault_cycle", cyc, e.cyc);
          chk("fault_cause", 32'(bus.FaultCause), 32'(e.cause));
          chk("fault_pc", bus.PC, e.pc);
          chk("fault_redir", dut.redirect_cnt_q, e.redir);
        end
      end
      if (m_trapped) begin
        chk("trap_fault", 32'(bus.Fault), 32'h1);
        chk("trap_req", 32'(bus.IMemReq), 32'h0);
        chk("trap_valid", 32'(bus.InstrValid), 32'h0);
        chk("trap_pc", bus.PC, m_trap_pc);
      end
      prev_req   = bus.IMemReq;
      prev_valid = bus.InstrValid;
      prev_fault = bus.Fault;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Random values on every input; callers override what must be specific.
  task automatic noise(input bit allow_done);
    bus.IMemAck   = 1'($urandom);
    bus.IMemRData = $urandom;
    bus.InstrDone = allow_done ? 1'($urandom) : 1'b0;
    bus.MUX3Res   = $urandom;
    bus.NextPCSrc = 1'($urandom);
  endtask

  // Hold reset for n edges, then release; returns in the FETCH cycle.
  task automatic do_reset(input int n, input bit force_ack);
    m_trapped = 0;
    rst_n = 1'b0;
    noise(1'b1);
    if (force_ack) bus.IMemAck = 1'b1;
    push_ev(EvReset, 0, RESET_PC, 32'h0, FAULT_NONE, 32'h0);
    repeat (n) begin
      step();
      noise(1'b1);
    end
    rst_n   = 1'b1;
    m_pc    = RESET_PC;
    m_redir = 32'h0;
    push_ev(EvReq, cyc + 1, m_pc, 32'h0, FAULT_NONE, 32'h0);
  endtask

  // Called in the FETCH cycle. result: 0 instruction valid, 1 timeout, 2 reset abort.
  task automatic do_fetch(input int ack_at, input int abort_at, input logic [31:0] data,
                          output int result);
    result = 1;
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      step();
      if (k == abort_at) begin
        do_reset(1, 1'b1);
        result = 2;
        return;
      end
      noise(1'b1);
      bus.IMemAck = (k == ack_at);
      if (k == ack_at) begin
        bus.IMemRData = data;
        push_ev(EvValid, cyc + 1, m_pc, data, FAULT_NONE, m_redir);
        result = 0;
        return;
      end
    end
    push_ev(EvFault, cyc + 1, m_pc, 32'h0, FAULT_TIMEOUT, m_redir);
  endtask

  // Let the core hold the instruction for a while, then retire it toward target.
  task automatic do_consume(input int hold, input logic [31:0] target, input bit nps,
                            output bit trapped);
    repeat (hold) begin
      step();
      noise(1'b0);
    end
    step();
    noise(1'b0);
    bus.InstrDone = 1'b1;
    bus.MUX3Res   = target;
    bus.NextPCSrc = nps;
    m_redir       = m_redir + 32'(nps);
    if (target[1:0] == 2'b00) begin
      m_pc = target;
      push_ev(EvReq, cyc + 1, m_pc, 32'h0, FAULT_NONE, 32'h0);
      step();
      noise(1'b1);
      trapped = 0;
    end else begin
      push_ev(EvFault, cyc + 1, m_pc, 32'h0, FAULT_MISALIGN, m_redir);
      trapped = 1;
    end
  endtask

  task automatic do_trap_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      m_trap_pc = m_pc;
      m_trapped = 1;
      noise(1'b1);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no end of test expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          res, ack_at, abort_at, hold, r;
    logic [31:0] tgt;
    bit          trapped;

    rst_n = 1'b0;
    noise(1'b1);
    do_reset(2, 1'b0);

    // First fetch after reset with an immediate ack, then a redirect to 8.
    do_fetch(1, 0, 32'h0050_0093, res);
    do_consume(2, 32'h0000_0008, 1'b1, trapped);
    // Walk the PC to the top of the address space and wrap through PCPlus4.
    do_fetch(3, 0, $urandom, res);
    do_consume(0, 32'hFFFF_FFFC, 1'b1, trapped);
    do_fetch(2, 0, $urandom, res);
    do_consume(1, m_pc + 32'd4, 1'b0, trapped);
    // Misaligned target traps and stays trapped.
    do_fetch(1, 0, $urandom, res);
    do_consume(1, 32'h0000_000A, 1'b1, trapped);
    do_trap_idle(20);
    do_reset(1, 1'b0);
    // Memory never acks.
    do_fetch(ACK_TIMEOUT + 5, 0, $urandom, res);
    do_trap_idle(5);
    do_reset(1, 1'b0);
    // Ack on the last permitted WAIT cycle.
    do_fetch(ACK_TIMEOUT, 0, 32'hCAFE_0013, res);
    do_consume(0, 32'h0000_0100, 1'b0, trapped);
    // Reset lands on an edge carrying an ack.
    do_fetch(0, 3, $urandom, res);

    for (int it = 0; it < 40; it++) begin
      r        = $urandom_range(0, 99);
      abort_at = (r < 5) ? $urandom_range(1, 4) : 0;
      ack_at   = (r < 85) ? $urandom_range(1, 5) : $urandom_range(1, ACK_TIMEOUT + 2);
      do_fetch(ack_at, abort_at, $urandom, res);
      if (res == 1) begin
        do_trap_idle(3);
        do_reset(1, 1'b0);
      end else if (res == 0) begin
        hold = $urandom_range(0, 3);
        r    = $urandom_range(0, 99);
        tgt  = $urandom;
        if (r < 15) begin
          if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
        end else if (r < 55) begin
          tgt = m_pc + 32'd4;
        end else begin
          tgt = tgt & 32'hFFFF_FFFC;
        end
        do_consume(hold, tgt, 1'($urandom), trapped);
        if (trapped) begin
          do_trap_idle(3);
          do_reset($urandom_range(1, 2), 1'b0);
        end
      end
    end

    repeat (3) step();
    chk("events_pending", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
